uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-stream command interpreter placed downstream of the `uart` receiver and upstream of its transmitter, replacing the loopback wiring. It consumes `rxdata`/`rx_enable` strobes, parses ASCII register commands (`Waadd<CR>`, `Raa<CR>`) and drives a simple 8-bit register bus. It returns a paced ASCII response to the uart's `txdata`/`tx_enable` inputs.

## Interface
- `TX_GAP`, 2816: clocks between successive `tx_enable` pulses; must cover one 10-bit frame at `clk32`, which is 2778 cycles at 115200 baud.
- `GAP_W`, 12: width of the gap counter; must satisfy 2^GAP_W > TX_GAP.
- `clk`  in  1  single system clock, drives the uart's `clk32`.
- `reset_`  in  1  asynchronous, active-low reset.
- `rx_enable`  in  1  one-cycle strobe; `rxdata` is valid in that cycle.
- `rxdata`  in  8  received byte.
- `tx_enable`  out  1  one-cycle strobe to the uart transmitter.
- `txdata`  out  8  byte to transmit; valid while `tx_enable` is high and held between strobes.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid in the cycle after `reg_re`.
- `overrun`  out  1  sticky flag: an rx byte was dropped while a response was in progress. Cleared only by reset.

## Operation
- Hex digits are accepted in either case: 0-9, A-F, a-f. The command letter is case-insensitive (`W`/`w`, `R`/`r`).
- LF (0x0A) is ignored in every parse state.
- Parse states:
  - `IDLE`
    - `W` → `ADDR_HI` with write flag set.
    - `R` → `ADDR_HI` with write flag clear.
    - CR → stay in `IDLE`, no response.
    - Any other byte → `DISCARD`.
  - `ADDR_HI`, `ADDR_LO`: each hex digit fills a nibble of the address, MS nibble first. After `ADDR_LO`, a write goes to `DATA_HI` and a read goes to `WAIT_CR`.
  - `DATA_HI`, `DATA_LO`: fill the data nibbles the same way, then go to `WAIT_CR`.
  - `WAIT_CR`: CR → `BUS`. Any other byte → `DISCARD`.
  - A non-hex byte in any digit state → `DISCARD`.
  - A CR in any digit state (line too short) → `RESP` with error response.
  - `DISCARD`: drop every byte until CR, then `RESP` with error response.
  - `BUS`:
    - Pulse `reg_we` for a write, or `reg_re` for a read, for one cycle.
    - A write then goes to `RESP`. A read goes to `RDWAIT`.
  - `RDWAIT`: capture `reg_rdata`, then go to `RESP`.
  - `RESP`: transmit the response buffer, then go to `IDLE`.
- Responses:
  - Write: `K` `<CR>` (0x4B, 0x0D).
  - Read: two uppercase hex digits, MS nibble first, then `<CR>`.
  - Error: `E` `<CR>` (0x45, 0x0D).
- `reg_addr` and `reg_wdata` hold their last parsed values at all times.
- Any `rx_enable` seen in `BUS`, `RDWAIT` or `RESP` is dropped and sets `overrun`.

## Timing
- Reset values: all outputs 0, state `IDLE`, gap counter 0.
- Reset asserted mid-command or mid-response aborts immediately. No further strobes are issued.
- Let N be the cycle in which the terminating CR strobe is seen.
- Write command:
  - `reg_we` at N+1.
  - First `tx_enable` at N+2.
  - Second `tx_enable` at N+2+TX_GAP.
- Read command:
  - `reg_re` at N+1.
  - `reg_rdata` sampled at N+2.
  - `tx_enable` at N+3, N+3+TX_GAP and N+3+2·TX_GAP.
- Error response: first `tx_enable` at N+1.
- After the last `tx_enable` the block stays in `RESP` for TX_GAP more cycles, then enters `IDLE`. The first byte accepted again is in the cycle after that.
- At most one of `reg_we`/`reg_re` is high in any cycle. Each is high for exactly one cycle per command.
- Back-to-back rx strobes on consecutive cycles are all accepted in parse states.

## Test plan
- Send `W3A5C<CR>` → `reg_we` for one cycle with addr 0x3A, wdata 0x5C, at CR+1. tx sends 0x4B at CR+2, then 0x0D TX_GAP later.
- Send `r3a<CR>` with `reg_rdata`=0xF0 → `reg_re` at CR+1, addr 0x3A. tx sends 0x46, 0x30, 0x0D at CR+3, +TX_GAP, +2·TX_GAP.
- Send `W3G5C<CR>`, `Q<CR>` and `R3<CR>` → each produces 0x45, 0x0D. No `reg_we`/`reg_re` pulses.
- Send `<CR>` alone, then `W0102<LF><CR>` → the lone CR gets no response. The second command writes addr 0x01, data 0x02.
- Send a byte during a read response → `overrun`=1 and the response is unaltered. Assert `reset_` mid-response → all outputs 0 and no further `tx_enable`.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// ASCII register-command parser between the uart receiver and transmitter: Waadd<CR> writes, Raa<CR> reads.
// Bus strobe one cycle after the CR. Response bytes are TX_GAP apart. Rx bytes that arrive during bus/response are dropped and flagged.
module uart_cmd_parser #(
  parameter int TX_GAP = 2816,
  parameter int GAP_W  = 12
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       rx_enable,
  input  logic [7:0] rxdata,
  output logic       tx_enable,
  output logic [7:0] txdata,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       overrun
);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(TX_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_CR, DISCARD, BUS, RDWAIT, RESP
  } state_t;

  state_t           state_q;
  logic             wr_q;
  logic [7:0]       addr_q, wdata_q, txdata_q, rest0_q, rest1_q;
  logic             we_q, re_q, txen_q, ovr_q;
  logic [1:0]       rem_q;
  logic [GAP_W-1:0] gap_q;

  function automatic logic hex_ok(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // 'A' (0x41) and 'a' (0x61) both carry 1 in the low nibble, so +9 gives 10.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  logic rx_byte;
  assign rx_byte = rx_enable && (rxdata != CH_LF);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      txdata_q <= 8'h00;
      rest0_q  <= 8'h00;
      rest1_q  <= 8'h00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      txen_q   <= 1'b0;
      ovr_q    <= 1'b0;
      rem_q    <= 2'd0;
      gap_q    <= '0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      txen_q <= 1'b0;
      if (rx_enable && (state_q == BUS || state_q == RDWAIT || state_q == RESP))
        ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (rx_byte) begin
          if (rxdata == 8'h57 || rxdata == 8'h77) begin
            wr_q    <= 1'b1;
            state_q <= ADDR_HI;
          end else if (rxdata == 8'h52 || rxdata == 8'h72) begin
            wr_q    <= 1'b0;
            state_q <= ADDR_HI;
          end else if (rxdata != CH_CR) begin
            state_q <= DISCARD;
          end
        end
        ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, DISCARD: if (rx_byte) begin
          if (rxdata == CH_CR) begin
            txen_q   <= 1'b1;
            txdata_q <= CH_E;
            rest0_q  <= CH_CR;
            rem_q    <= 2'd1;
            gap_q    <= GAP_RELOAD;
            state_q  <= RESP;
          end else if (state_q == DISCARD) begin
            state_q <= DISCARD;
          end else if (!hex_ok(rxdata)) begin
            state_q <= DISCARD;
          end else begin
            case (state_q)
              ADDR_HI: begin addr_q[7:4]  <= hex_val(rxdata); state_q <= ADDR_LO; end
              ADDR_LO: begin
                addr_q[3:0] <= hex_val(rxdata);
                state_q     <= wr_q ? DATA_HI : WAIT_CR;
              end
              DATA_HI: begin wdata_q[7:4] <= hex_val(rxdata); state_q <= DATA_LO; end
              DATA_LO: begin wdata_q[3:0] <= hex_val(rxdata); state_q <= WAIT_CR; end
              default: ;
            endcase
          end
        end
        WAIT_CR: if (rx_byte) begin
          if (rxdata == CH_CR) begin
            we_q    <= wr_q;
            re_q    <= !wr_q;
            state_q <= BUS;
          end else begin
            state_q <= DISCARD;
          end
        end
        BUS: if (wr_q) begin
          txen_q   <= 1'b1;
          txdata_q <= CH_K;
          rest0_q  <= CH_CR;
          rem_q    <= 2'd1;
          gap_q    <= GAP_RELOAD;
          state_q  <= RESP;
        end else begin
          state_q <= RDWAIT;
        end
        RDWAIT: begin
          txen_q   <= 1'b1;
          txdata_q <= hex_chr(reg_rdata[7:4]);
          rest0_q  <= hex_chr(reg_rdata[3:0]);
          rest1_q  <= CH_CR;
          rem_q    <= 2'd2;
          gap_q    <= GAP_RELOAD;
          state_q  <= RESP;
        end
        // The final countdown after the last byte lets its frame finish before new input.
        RESP: if (gap_q != '0) begin
          gap_q <= gap_q - GAP_W'(1);
        end else if (rem_q != 2'd0) begin
          txen_q   <= 1'b1;
          txdata_q <= rest0_q;
          rest0_q  <= rest1_q;
          rem_q    <= rem_q - 2'd1;
          gap_q    <= GAP_RELOAD;
        end else begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_enable = txen_q;
  assign txdata    = txdata_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Random and directed command lines checked against a line-level model of the command grammar.
module tb_uart_cmd_parser;
  localparam int GAP = 48;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       rx_enable = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic [7:0] reg_rdata = 8'h00;
  logic       tx_enable, reg_we, reg_re, overrun;
  logic [7:0] txdata, reg_addr, reg_wdata;

  uart_cmd_parser #(.TX_GAP(GAP), .GAP_W(12)) dut (
    .clk(clk), .reset_(reset_), .rx_enable(rx_enable), .rxdata(rxdata),
    .tx_enable(tx_enable), .txdata(txdata), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int         tx_c[$], we_c[$], re_c[$];
  logic [7:0] tx_d[$], we_a[$], we_w[$], re_a[$];
  always @(negedge clk) begin
    if (tx_enable) begin tx_c.push_back(cyc); tx_d.push_back(txdata); end
    if (reg_we) begin we_c.push_back(cyc); we_a.push_back(reg_addr); we_w.push_back(reg_wdata); end
    if (reg_re) begin re_c.push_back(cyc); re_a.push_back(reg_addr); end
  end

  // Read data is only meaningful in the cycle after reg_re; otherwise it is noise.
  logic [7:0] rd_val = 8'h00;
  bit         rd_arm = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rd_arm) begin
      reg_rdata = rd_val;
      rd_arm = 1'b0;
    end else begin
      reg_rdata = 8'($urandom_range(0, 255));
      if (reg_re) rd_arm = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hval(input logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  function automatic logic [7:0] hchr(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [7:0] rand_hex();
    int n = $urandom_range(0, 15);
    if (n < 10) return 8'(48 + n);
    return ($urandom_range(0, 1) == 1) ? 8'(55 + n) : 8'(87 + n);
  endfunction

  function automatic logic [7:0] rand_nonhex();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_hex(b) || b == 8'h0A || b == 8'h0D);
    return b;
  endfunction

  logic [7:0] cmd[$];
  logic       ovr_exp = 1'b0;

  task automatic set_str(input string s);
    cmd.delete();
    for (int i = 0; i < s.len(); i++) cmd.push_back(s[i]);
  endtask

  task automatic gen_rand();
    int t = $urandom_range(0, 10);
    bit w = ($urandom_range(0, 1) == 1);
    int nd = w ? 4 : 2;
    logic [7:0] b;
    cmd.delete();
    if (t != 10) begin
      if (t == 7) begin
        do b = 8'($urandom_range(0, 255));
        while ((b | 8'h20) == 8'h77 || (b | 8'h20) == 8'h72 || b == 8'h0A || b == 8'h0D);
        cmd.push_back(b);
        repeat ($urandom_range(0, 3)) cmd.push_back(rand_nonhex());
      end else begin
        cmd.push_back(w ? (($urandom_range(0, 1) == 1) ? 8'h57 : 8'h77)
                        : (($urandom_range(0, 1) == 1) ? 8'h52 : 8'h72));
        if (t == 8) nd = $urandom_range(0, nd - 1);
        if (t == 9) nd = nd + 1;
        for (int i = 0; i < nd; i++) cmd.push_back(rand_hex());
        if (t == 6) cmd[$urandom_range(1, cmd.size() - 1)] = rand_nonhex();
      end
    end
    if ($urandom_range(0, 3) == 0) cmd.insert($urandom_range(0, cmd.size()), 8'h0A);
    cmd.push_back(8'h0D);
  endtask

  // Line-level grammar: 0 no response, 1 write, 2 read, 3 error.
  task automatic model(output int kind, output logic [7:0] a, output logic [7:0] d);
    logic [7:0] l[$];
    bit ok;
    foreach (cmd[i]) if (cmd[i] != 8'h0A && cmd[i] != 8'h0D) l.push_back(cmd[i]);
    a = 8'h00; d = 8'h00;
    if (l.size() == 0) begin kind = 0; return; end
    ok = 1'b1;
    for (int i = 1; i < l.size(); i++) if (!is_hex(l[i])) ok = 1'b0;
    if ((l[0] | 8'h20) == 8'h77 && l.size() == 5 && ok) begin
      kind = 1;
      a = 8'(hval(l[1]) * 16 + hval(l[2]));
      d = 8'(hval(l[3]) * 16 + hval(l[4]));
    end else if ((l[0] | 8'h20) == 8'h72 && l.size() == 3 && ok) begin
      kind = 2;
      a = 8'(hval(l[1]) * 16 + hval(l[2]));
    end else begin
      kind = 3;
    end
  endtask

  task automatic send(output int n);
    n = 0;
    foreach (cmd[i]) begin
      if (i > 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rx_enable = 1'b1;
      rxdata = cmd[i];
      n = cyc;
      @(posedge clk); #1;
      rx_enable = 1'b0;
    end
  endtask

  task automatic clear_q();
    tx_c.delete(); tx_d.delete(); we_c.delete(); we_a.delete(); we_w.delete();
    re_c.delete(); re_a.delete();
  endtask

  task automatic run_cmd(input logic [7:0] rd, input bit inject);
    int kind, n, first, done, ncmp;
    logic [7:0] a, d;
    logic [7:0] exp_d[$];
    rd_val = rd;
    model(kind, a, d);
    case (kind)
      1: begin first = 2; exp_d = '{8'h4B, 8'h0D}; end
      2: begin first = 3; exp_d = '{hchr(rd / 16), hchr(rd % 16), 8'h0D}; end
      3: begin first = 1; exp_d = '{8'h45, 8'h0D}; end
      default: first = 1;
    endcase
    send(n);
    done = (kind == 0) ? n + 1 : n + first + exp_d.size() * GAP;
    while (cyc < done) begin
      if (inject && cyc == n + 3 + GAP / 2) begin
        rx_enable = 1'b1; rxdata = 8'h57; ovr_exp = 1'b1;
      end
      @(posedge clk); #1;
      rx_enable = 1'b0;
    end
    chk("tx_count", tx_c.size(), exp_d.size());
    ncmp = (tx_c.size() < exp_d.size()) ? tx_c.size() : exp_d.size();
    for (int i = 0; i < ncmp; i++) begin
      chk("tx_cycle", tx_c[i] - n, first + i * GAP);
      chk("tx_data", tx_d[i], exp_d[i]);
    end
    chk("we_count", we_c.size(), (kind == 1) ? 1 : 0);
    if (kind == 1 && we_c.size() > 0) begin
      chk("we_cycle", we_c[0] - n, 1);
      chk("we_addr", we_a[0], a);
      chk("we_wdata", we_w[0], d);
    end
    chk("re_count", re_c.size(), (kind == 2) ? 1 : 0);
    if (kind == 2 && re_c.size() > 0) begin
      chk("re_cycle", re_c[0] - n, 1);
      chk("re_addr", re_a[0], a);
    end
    chk("overrun", overrun, ovr_exp);
    clear_q();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_txdata", txdata, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_overrun", overrun, 0);
    reset_ = 1'b1;
    @(posedge clk); #1;
    clear_q();

    set_str("W3A5C"); cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);
    set_str("r3a");   cmd.push_back(8'h0D); run_cmd(8'hF0, 1'b0);
    set_str("W3G5C"); cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);
    set_str("Q");     cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);
    set_str("R3");    cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);
    cmd.delete();     cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);
    set_str("W0102"); cmd.push_back(8'h0A); cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);

    for (int k = 0; k < 60; k++) begin
      gen_rand();
      run_cmd(8'($urandom_range(0, 255)), 1'b0);
    end

    set_str("Rc7"); cmd.push_back(8'h0D); run_cmd(8'h9B, 1'b1);
    set_str("w1122"); cmd.push_back(8'h0D); run_cmd(8'h00, 1'b0);

    set_str("W4455"); cmd.push_back(8'h0D);
    send(n);
    while (cyc < n + 2 + GAP / 2) begin @(posedge clk); #1; end
    reset_ = 1'b0;
    #1;
    chk("mid_rst_tx_enable", tx_enable, 0);
    chk("mid_rst_txdata", txdata, 0);
    chk("mid_rst_reg_addr", reg_addr, 0);
    chk("mid_rst_reg_wdata", reg_wdata, 0);
    chk("mid_rst_reg_we", reg_we, 0);
    chk("mid_rst_reg_re", reg_re, 0);
    chk("mid_rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_ = 1'b1;
    repeat (3 * GAP) @(posedge clk);
    #1;
    chk("post_rst_tx_count", tx_c.size(), 1);
    if (tx_d.size() > 0) chk("post_rst_tx_data", tx_d[0], 8'h4B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
